motor_status_debouncer: RTL

MOTOR_STATUS_DEBOUNCER -- requirements
Module: motor_status_debouncer

---
 rtl/motor_status_debouncer_pkg.sv | 18 +
 rtl/motor_status_debouncer_if.sv | 26 ++
 rtl/motor_status_debouncer_debounce_bit.sv | 43 ++++
 rtl/motor_status_debouncer.sv | 125 ++++++++++++
 4 files changed

// File: rtl/motor_status_debouncer_pkg.sv
// Shared types for the motor status debouncer: clock/reset bundle and the
// encoding of which status input produced an event.
package motor_status_debouncer_pkg;

   typedef struct packed {
      logic clk;
      logic reset;
   } ckrs_t;

   typedef enum logic [1:0] {
      EV_PFAIL = 2'd0,
      EV_SW_A  = 2'd1,
      EV_SW_B  = 2'd2
   } motor_event_kind_t;

   localparam int KINDS_PER_CHANNEL = 3;

endpackage

// File: rtl/motor_status_debouncer_if.sv
// Event handshake and overrun bundle of the motor status debouncer; master is
// the debouncer side, slave is the event consumer.
interface motor_status_debouncer_if #(
   parameter int NCHANNELS = 16
);
   import motor_status_debouncer_pkg::*;

   logic                           event_valid;
   logic                           event_ready;
   logic [$clog2(NCHANNELS+1)-1:0] event_channel;
   motor_event_kind_t              event_kind;
   logic                           event_level;
   logic [3*NCHANNELS-1:0]         overrun;
   logic                           overrun_clear;

   modport master (
      output event_valid, event_channel, event_kind, event_level, overrun,
      input  event_ready, overrun_clear
   );

   modport slave (
      input  event_valid, event_channel, event_kind, event_level, overrun,
      output event_ready, overrun_clear
   );

endinterface

// File: rtl/motor_status_debouncer_debounce_bit.sv
// One status input: 2-FF synchroniser followed by a stability counter that
// flips the debounced level after DEBOUNCE_CYCLES consecutive differing samples.
module debounce_bit #(
   parameter int DEBOUNCE_CYCLES = 1000
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic raw_i,
   output logic level_o,
   output logic toggle_o
);
   localparam int              CW       = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [1:0]    sync_q;
   logic          level_q, level_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          differ, toggle;

   // toggle is exposed combinationally so the parent can mark the event on the same edge
   always_comb begin
      differ = sync_q[1] ^ level_q;
      toggle = differ && (cnt_q == CNT_LAST);
      cnt_d  = (!differ || toggle) ? '0 : cnt_q + CW'(1);
      level_d = level_q ^ toggle;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync_q  <= '0;
         level_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync_q  <= {sync_q[0], raw_i};
         level_q <= level_d;
         cnt_q   <= cnt_d;
      end
   end

   assign level_o  = level_q;
   assign toggle_o = toggle;

endmodule

// File: rtl/motor_status_debouncer.sv
// Debounces three status inputs per motor channel and reports every debounced
// change as an event through a round-robin arbiter and a valid/ready register.
module motor_status_debouncer
   import motor_status_debouncer_pkg::*;
#(
   parameter int NCHANNELS       = 16,
   parameter int DEBOUNCE_CYCLES = 1000
) (
   input  ckrs_t                          ClkRs_ix,
   input  logic [1:NCHANNELS]             pl_pfail_i,
   input  logic [1:NCHANNELS]             pl_sw_outa_i,
   input  logic [1:NCHANNELS]             pl_sw_outb_i,
   output logic [1:NCHANNELS]             pfail_ob,
   output logic [1:NCHANNELS]             sw_outa_ob,
   output logic [1:NCHANNELS]             sw_outb_ob,
   output logic                           event_valid_o,
   input  logic                           event_ready_i,
   output logic [$clog2(NCHANNELS+1)-1:0] event_channel_o,
   output motor_event_kind_t              event_kind_o,
   output logic                           event_level_o,
   output logic [3*NCHANNELS-1:0]         overrun_o,
   input  logic                           overrun_clear_i
);
   localparam int NIDX = KINDS_PER_CHANNEL * NCHANNELS;
   localparam int IW   = $clog2(NIDX);
   localparam int CHW  = $clog2(NCHANNELS + 1);

   logic clk, rst;
   assign clk = ClkRs_ix.clk;
   assign rst = ClkRs_ix.reset;

   logic [NIDX-1:0] rawVec, levelVec, toggleVec;

   for (genvar ch = 1; ch <= NCHANNELS; ch++) begin : g_chan
      assign rawVec[3*(ch-1)+int'(EV_PFAIL)] = pl_pfail_i[ch];
      assign rawVec[3*(ch-1)+int'(EV_SW_A)]  = pl_sw_outa_i[ch];
      assign rawVec[3*(ch-1)+int'(EV_SW_B)]  = pl_sw_outb_i[ch];
      assign pfail_ob[ch]   = levelVec[3*(ch-1)+int'(EV_PFAIL)];
      assign sw_outa_ob[ch] = levelVec[3*(ch-1)+int'(EV_SW_A)];
      assign sw_outb_ob[ch] = levelVec[3*(ch-1)+int'(EV_SW_B)];
   end

   for (genvar i = 0; i < NIDX; i++) begin : g_bit
      debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_bit (
         .clk_i    (clk),
         .rst_i    (rst),
         .raw_i    (rawVec[i]),
         .level_o  (levelVec[i]),
         .toggle_o (toggleVec[i])
      );
   end

   logic [NIDX-1:0]   pending_q, pending_d, overrun_q, overrun_d, loadMask;
   logic [IW-1:0]     ptr_q, ptr_d, selIdx;
   logic [IW:0]       cand;
   logic              found, load;
   logic              valid_q, valid_d, level_q, level_d;
   logic [CHW-1:0]    chan_q, chan_d;
   motor_event_kind_t kind_q, kind_d;

   // first pending index at or after the pointer, wrapping once around the index space
   always_comb begin
      found  = 1'b0;
      selIdx = '0;
      cand   = '0;
      for (int j = 0; j < NIDX; j++) begin
         cand = {1'b0, ptr_q} + (IW+1)'(j);
         if (cand >= (IW+1)'(NIDX)) cand = cand - (IW+1)'(NIDX);
         if (!found && pending_q[cand[IW-1:0]]) begin
            found  = 1'b1;
            selIdx = cand[IW-1:0];
         end
      end
   end

   // a toggle landing on the index being loaded re-arms it instead of counting as an overrun
   always_comb begin
      load     = found && (!valid_q || event_ready_i);
      loadMask = '0;
      if (load) loadMask[selIdx] = 1'b1;
      pending_d = (pending_q & ~loadMask) | toggleVec;
      overrun_d = (overrun_clear_i ? '0 : overrun_q) | (toggleVec & pending_q & ~loadMask);
      ptr_d    = ptr_q;
      valid_d  = valid_q;
      chan_d   = chan_q;
      kind_d   = kind_q;
      level_d  = level_q;
      if (load) begin
         ptr_d   = (int'(selIdx) == NIDX - 1) ? '0 : selIdx + IW'(1);
         valid_d = 1'b1;
         chan_d  = CHW'(int'(selIdx) / 3 + 1);
         kind_d  = motor_event_kind_t'(2'(int'(selIdx) % 3));
         level_d = levelVec[selIdx];
      end else if (event_ready_i) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pending_q <= '0;
         overrun_q <= '0;
         ptr_q     <= '0;
         valid_q   <= 1'b0;
         chan_q    <= '0;
         kind_q    <= EV_PFAIL;
         level_q   <= 1'b0;
      end else begin
         pending_q <= pending_d;
         overrun_q <= overrun_d;
         ptr_q     <= ptr_d;
         valid_q   <= valid_d;
         chan_q    <= chan_d;
         kind_q    <= kind_d;
         level_q   <= level_d;
      end
   end

   assign event_valid_o   = valid_q;
   assign event_channel_o = chan_q;
   assign event_kind_o    = kind_q;
   assign event_level_o   = level_q;
   assign overrun_o       = overrun_q;

endmodule
